rocket_vpos: RTL and testbench

Per-player rocket vertical position and rocket video generator for Space Race. It consumes the frame-timing strobes produced by the miscellaneous-video block (R_RESET, R_BBOUND, V_WINDOW) and the vertical count. It updates the rocket's Y position once per frame from the player's joystick and detects star collisions against the star video. It drives the active-low rocket video and graphic row address back into the video mix, plus STOP and score-increment events for game control.

---
 rtl/rocket_vpos.sv | 128 ++++++++++++
 tb/tb_rocket_vpos.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rocket_vpos.sv
// Space Race per-player rocket: once-per-frame Y update from the joystick,
// star-collision fall-back, and registered rocket video / graphic row output.
module rocket_vpos #(
  parameter int HOME       = 208,
  parameter int TOP        = 8,
  parameter int SPEED      = 1,
  parameter int FALL_SPEED = 2,
  parameter int ROCKET_H   = 16
) (
  input  logic       CLK_DRV,
  input  logic       RESET,
  input  logic [7:0] V,
  input  logic       V_WINDOW,
  input  logic       R_RESET,
  input  logic       R_BBOUND,
  input  logic       ROCKET_HWIN,
  input  logic       STARS_N,
  input  logic       ENABLE,
  input  logic       UP,
  input  logic       DOWN,
  output logic       ROCKET_N,
  output logic [3:0] ROW,
  output logic [7:0] YPOS,
  output logic       STOP,
  output logic       SCORE_INC
);

  localparam logic [8:0] HOME9 = 9'(HOME);
  localparam logic [8:0] LIM9  = 9'(TOP + SPEED);
  localparam logic [8:0] SPD9  = 9'(SPEED);
  localparam logic [8:0] FSPD9 = 9'(FALL_SPEED);
  localparam logic [7:0] HOME8 = 8'(HOME);
  localparam logic [7:0] SPD8  = 8'(SPEED);
  localparam logic [7:0] RH8   = 8'(ROCKET_H);

  typedef enum logic {FLY, FALL} state_t;

  state_t     state;
  logic [7:0] ypos;
  logic       hitl;
  logic       hit;
  logic       rr_q;
  logic       bb_q;
  logic       rocket_n;
  logic [3:0] row;
  logic       score_inc;

  logic       rr_rise;
  logic       bb_rise;
  logic [8:0] up_sum;
  logic [8:0] fall_sum;
  logic [7:0] down_y;
  logic [7:0] fall_y;
  logic [7:0] d;
  logic       in_range;

  always_comb begin
    rr_rise  = R_RESET & ~rr_q;
    bb_rise  = R_BBOUND & ~bb_q;
    up_sum   = {1'b0, ypos} + SPD9;
    fall_sum = {1'b0, ypos} + FSPD9;
    down_y   = (up_sum >= HOME9) ? HOME8 : up_sum[7:0];
    fall_y   = (fall_sum >= HOME9) ? HOME8 : fall_sum[7:0];
    d        = V - ypos;
    in_range = V_WINDOW && (d < RH8);
  end

  // Edge detectors come out of reset as "already high" so releasing reset
  // in the middle of R_BBOUND cannot fake a frame update.
  // The collision latch is sampled into hit at R_RESET and cleared there, so
  // the update at R_BBOUND acts on the hits from the frame just rendered.
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      state     <= FLY;
      ypos      <= HOME8;
      hitl      <= 1'b0;
      hit       <= 1'b0;
      rr_q      <= 1'b1;
      bb_q      <= 1'b1;
      rocket_n  <= 1'b1;
      row       <= '0;
      score_inc <= 1'b0;
    end else begin
      rr_q      <= R_RESET;
      bb_q      <= R_BBOUND;
      score_inc <= 1'b0;
      rocket_n  <= ~(in_range & ROCKET_HWIN);
      row       <= in_range ? d[3:0] : '0;

      if (rr_rise) begin
        hit  <= hitl;
        hitl <= 1'b0;
      end else if (state == FLY && !rocket_n && !STARS_N) begin
        hitl <= 1'b1;
      end

      if (bb_rise) begin
        if (!ENABLE) begin
          ypos  <= HOME8;
          state <= FLY;
        end else if (state == FLY) begin
          if (hit) begin
            state <= FALL;
          end else if (UP && !DOWN) begin
            if ({1'b0, ypos} <= LIM9) begin
              ypos      <= HOME8;
              score_inc <= 1'b1;
            end else begin
              ypos <= ypos - SPD8;
            end
          end else if (DOWN && !UP) begin
            ypos <= down_y;
          end
        end else begin
          ypos <= fall_y;
          if (fall_y == HOME8) state <= FLY;
        end
      end
    end
  end

  assign ROCKET_N  = rocket_n;
  assign ROW       = row;
  assign YPOS      = ypos;
  assign SCORE_INC = score_inc;
  assign STOP      = (state == FLY) && (ypos == HOME8);

endmodule

// File: tb/tb_rocket_vpos.sv
// Directed bench for rocket_vpos: frame-by-frame joystick, collision and
// reset scenarios with a scoreboard for the rendered rocket video.
module tb_rocket_vpos;

  logic       CLK_DRV;
  logic       RESET;
  logic [7:0] V;
  logic       V_WINDOW;
  logic       R_RESET;
  logic       R_BBOUND;
  logic       ROCKET_HWIN;
  logic       STARS_N;
  logic       ENABLE;
  logic       UP;
  logic       DOWN;
  logic       ROCKET_N;
  logic [3:0] ROW;
  logic [7:0] YPOS;
  logic       STOP;
  logic       SCORE_INC;

  rocket_vpos dut (
    .CLK_DRV(CLK_DRV), .RESET(RESET), .V(V), .V_WINDOW(V_WINDOW),
    .R_RESET(R_RESET), .R_BBOUND(R_BBOUND), .ROCKET_HWIN(ROCKET_HWIN),
    .STARS_N(STARS_N), .ENABLE(ENABLE), .UP(UP), .DOWN(DOWN),
    .ROCKET_N(ROCKET_N), .ROW(ROW), .YPOS(YPOS), .STOP(STOP),
    .SCORE_INC(SCORE_INC)
  );

  initial CLK_DRV = 1'b0;
  always #5 CLK_DRV = ~CLK_DRV;

  typedef struct packed {
    logic       rn;
    logic [3:0] row;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   score_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One frame, one clock per line. Fast frames only run the vertical-blank
  // tail (lines 246..261) that carries R_RESET and R_BBOUND.
  task automatic frame(input bit full, input bit rchk, input int exp_y,
                       input int stars_lo, input bit hw_alt);
    logic [7:0] dd;
    logic       inr;
    logic       hw;
    exp_t       e;
    int         lo;
    lo = full ? 0 : 246;
    for (int l = lo; l < 262; l++) begin
      hw          = hw_alt ? (l % 2 == 0) : 1'b1;
      V           = 8'(l);
      V_WINDOW    = (l < 224);
      R_RESET     = (l == 248);
      R_BBOUND    = (l >= 249) && (l <= 256);
      ROCKET_HWIN = hw;
      STARS_N     = !(stars_lo >= 0 && l >= stars_lo && l < stars_lo + 16);
      if (rchk) begin
        dd    = 8'(l - exp_y);
        inr   = (l < 224) && (dd < 8'd16);
        e.rn  = ~(inr & hw);
        e.row = inr ? dd[3:0] : 4'd0;
        sb.push_back(e);
      end
      @(posedge CLK_DRV); #1;
      if (SCORE_INC) score_cnt++;
      if (rchk) begin
        e = sb.pop_front();
        chk("rocket_n", ROCKET_N, e.rn);
        chk("row", ROW, e.row);
      end
    end
    STARS_N = 1'b1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(0, 0, 0, -1, 0);
  endtask

  initial begin
    RESET = 1'b1; V = '0; V_WINDOW = 0; R_RESET = 0; R_BBOUND = 0;
    ROCKET_HWIN = 0; STARS_N = 1; ENABLE = 0; UP = 0; DOWN = 0;
    #1;
    chk("rst_ypos", YPOS, 208);
    chk("rst_stop", STOP, 1);
    chk("rst_rocket_n", ROCKET_N, 1);
    chk("rst_row", ROW, 0);
    chk("rst_score", SCORE_INC, 0);
    repeat (3) @(posedge CLK_DRV);
    #1 RESET = 1'b0;
    ENABLE = 1'b1;

    // Idle at home: rocket drawn on lines 208..223, even lines only.
    repeat (3) frame(1, 1, 208, -1, 1);
    chk("idle_ypos", YPOS, 208);
    chk("idle_stop", STOP, 1);

    UP = 1;
    for (int i = 1; i <= 10; i++) begin
      frame(0, 0, 0, -1, 0);
      chk("up_ypos", YPOS, 208 - i);
      if (i == 1) chk("up_stop", STOP, 0);
    end
    UP = 0; DOWN = 1;
    for (int i = 1; i <= 20; i++) begin
      frame(0, 0, 0, -1, 0);
      chk("down_ypos", YPOS, (198 + i > 208) ? 208 : 198 + i);
    end
    chk("down_stop", STOP, 1);
    chk("down_score", score_cnt, 0);

    // Climb to the top and cross.
    DOWN = 0; UP = 1;
    frames(198);
    chk("climb_ypos", YPOS, 10);
    chk("climb_score", score_cnt, 0);
    frame(0, 0, 0, -1, 0);
    chk("near_top_ypos", YPOS, 9);
    frame(0, 0, 0, -1, 0);
    chk("cross_ypos", YPOS, 208);
    chk("cross_score", score_cnt, 1);
    chk("cross_stop", STOP, 1);

    // Star hit at 100 while UP held, then fall 2 lines per frame.
    score_cnt = 0;
    frames(108);
    chk("pre_hit_ypos", YPOS, 100);
    frame(1, 1, 100, 100, 0);
    chk("hit_ypos", YPOS, 100);
    chk("hit_stop", STOP, 0);
    for (int i = 1; i <= 54; i++) begin
      frame(0, 0, 0, -1, 0);
      chk("fall_ypos", YPOS, 100 + 2 * i);
    end
    chk("landed_stop", STOP, 1);
    frame(0, 0, 0, -1, 0);
    chk("fly_again_ypos", YPOS, 207);
    chk("fall_score", score_cnt, 0);

    // Hit at the crossing line: hit wins, no score.
    frames(198);
    chk("pre_hit9_ypos", YPOS, 9);
    frame(1, 1, 9, 9, 0);
    chk("hit9_ypos", YPOS, 9);
    chk("hit9_score", score_cnt, 0);
    frames(99);
    chk("fall9_ypos", YPOS, 207);
    chk("fall9_stop", STOP, 0);
    frame(0, 0, 0, -1, 0);
    chk("fall9_home", YPOS, 208);
    chk("fall9_stop_home", STOP, 1);
    frame(0, 0, 0, -1, 0);
    chk("after_fall9", YPOS, 207);

    DOWN = 1;
    frames(3);
    chk("both_hold", YPOS, 207);
    DOWN = 0;
    frames(157);
    chk("pre_dis_ypos", YPOS, 50);
    ENABLE = 0;
    frame(0, 0, 0, -1, 0);
    chk("disable_ypos", YPOS, 208);
    chk("disable_stop", STOP, 1);
    ENABLE = 1;
    chk("total_score", score_cnt, 0);

    // Reset in the middle of a fall.
    frames(20);
    chk("pre_hit188", YPOS, 188);
    frame(1, 1, 188, 188, 0);
    chk("hit188_ypos", YPOS, 188);
    frame(0, 0, 0, -1, 0);
    chk("fall188_ypos", YPOS, 190);
    V = 8'd20; V_WINDOW = 1; ROCKET_HWIN = 1;
    repeat (5) @(posedge CLK_DRV);
    #3 RESET = 1'b1;
    #1;
    chk("midrst_ypos", YPOS, 208);
    chk("midrst_stop", STOP, 1);
    chk("midrst_rocket_n", ROCKET_N, 1);
    chk("midrst_row", ROW, 0);
    @(posedge CLK_DRV); #1 RESET = 1'b0;
    frame(0, 0, 0, -1, 0);
    chk("post_rst_ypos", YPOS, 207);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
